// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, register-zero constant and writeback source encoding
// for the register-file write-port arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_BUF,
    SRC_WB,
    SRC_MD
  } src_sel_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_skid_buf.sv
// One-entry holding buffer for a multi-cycle result that lost arbitration.
// Loaded only while empty; drained when the arbiter selects it.
module regfile_wb_arbiter_wb_skid_buf
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  load,
  input  logic [REG_ADDR_W-1:0] load_rw,
  input  logic [REG_DATA_W-1:0] load_data,
  input  logic                  drain,
  output logic                  full,
  output logic [REG_ADDR_W-1:0] rw,
  output logic [REG_DATA_W-1:0] data
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full <= 1'b0;
      rw   <= '0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      rw   <= load_rw;
      data <= load_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. multi-cycle results,
// with a busy scoreboard driving decode stall and a starvation hold on writeback.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_WbValid,
  input  logic [REG_ADDR_W-1:0] i_WbRW,
  input  logic [REG_DATA_W-1:0] i_WbData,
  input  logic                  i_MdValid,
  input  logic [REG_ADDR_W-1:0] i_MdRW,
  input  logic [REG_DATA_W-1:0] i_MdData,
  output logic                  o_MdReady,
  input  logic                  i_IssueValid,
  input  logic [REG_ADDR_W-1:0] i_IssueRW,
  input  logic [REG_ADDR_W-1:0] i_RA,
  input  logic [REG_ADDR_W-1:0] i_RB,
  output logic                  o_Stall,
  output logic                  o_WbHold,
  output logic                  o_RegWrite,
  output logic [REG_ADDR_W-1:0] o_RW,
  output logic [REG_DATA_W-1:0] o_BusW,
  output logic [31:0]           o_Busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic                  buf_full;
  logic [REG_ADDR_W-1:0] buf_rw;
  logic [REG_DATA_W-1:0] buf_data;
  logic                  buf_load;
  logic                  buf_drain;
  logic                  md_fire;
  src_sel_e              sel;
  logic [REG_ADDR_W-1:0] sel_rw;
  logic [REG_DATA_W-1:0] sel_data;
  logic                  from_md;
  logic [3:0]            starve_cnt;
  logic [3:0]            starve_cnt_d;
  logic [31:0]           busy;
  logic [31:0]           busy_d;
  logic                  issue_set;

  assign o_MdReady = ~buf_full;
  assign md_fire   = i_MdValid & ~buf_full;

  regfile_wb_arbiter_wb_skid_buf u_skid (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .load      (buf_load),
    .load_rw   (i_MdRW),
    .load_data (i_MdData),
    .drain     (buf_drain),
    .full      (buf_full),
    .rw        (buf_rw),
    .data      (buf_data)
  );

  always_comb begin
    sel      = SRC_NONE;
    sel_rw   = '0;
    sel_data = '0;
    if (buf_full && (o_WbHold || !i_WbValid)) begin
      sel      = SRC_BUF;
      sel_rw   = buf_rw;
      sel_data = buf_data;
    end else if (i_WbValid) begin
      sel      = SRC_WB;
      sel_rw   = i_WbRW;
      sel_data = i_WbData;
    end else if (md_fire) begin
      sel      = SRC_MD;
      sel_rw   = i_MdRW;
      sel_data = i_MdData;
    end
  end

  // An accepted Md result that lost to Wb parks in the (necessarily empty) buffer.
  assign buf_load  = md_fire && (sel == SRC_WB);
  assign buf_drain = (sel == SRC_BUF);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_RegWrite <= 1'b0;
      o_RW       <= '0;
      o_BusW     <= '0;
      from_md    <= 1'b0;
    end else begin
      o_RegWrite <= (sel != SRC_NONE) && (sel_rw != REG_ZERO);
      o_RW       <= sel_rw;
      o_BusW     <= sel_data;
      from_md    <= (sel == SRC_BUF) || (sel == SRC_MD);
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt;
    if (buf_drain) starve_cnt_d = '0;
    else if (buf_full && starve_cnt != 4'hF) starve_cnt_d = starve_cnt + 4'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
      o_WbHold   <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_d;
      o_WbHold   <= (starve_cnt_d >= LIMIT);
    end
  end

  assign o_Stall = ((i_RA != REG_ZERO) && busy[i_RA]) ||
                   ((i_RB != REG_ZERO) && busy[i_RB]) ||
                   (i_IssueValid && (i_IssueRW != REG_ZERO) && busy[i_IssueRW]);

  assign issue_set = i_IssueValid && (i_IssueRW != REG_ZERO) && !o_Stall;

  // Clear applied before set so an issue landing on a retiring register keeps it busy.
  always_comb begin
    busy_d = busy;
    if (o_RegWrite && from_md) busy_d[o_RW] = 1'b0;
    if (issue_set) busy_d[i_IssueRW] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy <= '0;
    else          busy <= busy_d;
  end

  assign o_Busy = busy;

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(i_WbValid && o_WbHold))
        else $error("writeback presented while o_WbHold set; request lost");
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then random traffic,
// compared against a transaction-level model of the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_WbValid, i_MdValid, i_IssueValid;
  logic [4:0]  i_WbRW, i_MdRW, i_IssueRW, i_RA, i_RB;
  logic [31:0] i_WbData, i_MdData;
  logic        o_MdReady, o_Stall, o_WbHold, o_RegWrite;
  logic [4:0]  o_RW;
  logic [31:0] o_BusW, o_Busy;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_WbValid(i_WbValid), .i_WbRW(i_WbRW), .i_WbData(i_WbData),
    .i_MdValid(i_MdValid), .i_MdRW(i_MdRW), .i_MdData(i_MdData),
    .o_MdReady(o_MdReady),
    .i_IssueValid(i_IssueValid), .i_IssueRW(i_IssueRW),
    .i_RA(i_RA), .i_RB(i_RB),
    .o_Stall(o_Stall), .o_WbHold(o_WbHold),
    .o_RegWrite(o_RegWrite), .o_RW(o_RW), .o_BusW(o_BusW), .o_Busy(o_Busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rw;
    logic [31:0] data;
    int unsigned age;
  } ent_t;

  ent_t        skid_q[$];
  bit          m_busy[32];
  bit          m_we, m_md, m_hold;
  logic [4:0]  m_rw;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] busy_vec();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit exp_stall();
    return (i_RA != 0 && m_busy[i_RA]) || (i_RB != 0 && m_busy[i_RB]) ||
           (i_IssueValid && i_IssueRW != 0 && m_busy[i_IssueRW]);
  endfunction

  task automatic model_reset();
    skid_q.delete();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_we = 0; m_md = 0; m_hold = 0; m_rw = '0; m_data = '0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_update(input bit st);
    bit   full, fire;
    int   src;
    ent_t e;
    full = (skid_q.size() != 0);
    fire = i_MdValid && !full;
    if (full && (m_hold || !i_WbValid)) src = 1;
    else if (i_WbValid)                 src = 2;
    else if (fire)                      src = 3;
    else                                src = 0;
    if (m_we && m_md) m_busy[m_rw] = 1'b0;
    if (i_IssueValid && i_IssueRW != 0 && !st) m_busy[i_IssueRW] = 1'b1;
    case (src)
      1: begin m_rw = skid_q[0].rw; m_data = skid_q[0].data; m_md = 1; end
      2: begin m_rw = i_WbRW; m_data = i_WbData; m_md = 0; end
      3: begin m_rw = i_MdRW; m_data = i_MdData; m_md = 1; end
      default: m_md = 0;
    endcase
    m_we = (src != 0) && (m_rw != 0);
    if (src == 1) void'(skid_q.pop_front());
    else if (full) begin e = skid_q[0]; e.age++; skid_q[0] = e; end
    if (fire && src == 2) begin
      e.rw = i_MdRW; e.data = i_MdData; e.age = 0;
      skid_q.push_back(e);
    end
    m_hold = (skid_q.size() != 0) && (skid_q[0].age >= LIMIT);
  endtask

  task automatic step();
    bit st;
    #1;
    st = exp_stall();
    chk("stall", 32'(o_Stall), 32'(st));
    chk("md_ready_pre", 32'(o_MdReady), 32'(skid_q.size() == 0));
    model_update(st);
    @(posedge i_clk);
    #1;
    chk("reg_write", 32'(o_RegWrite), 32'(m_we));
    if (m_we) begin
      chk("rw", 32'(o_RW), 32'(m_rw));
      chk("busw", o_BusW, m_data);
    end
    chk("busy", o_Busy, busy_vec());
    chk("wb_hold", 32'(o_WbHold), 32'(m_hold));
    chk("md_ready", 32'(o_MdReady), 32'(skid_q.size() == 0));
  endtask

  task automatic set_idle();
    i_WbValid = 0; i_WbRW = '0; i_WbData = '0;
    i_MdValid = 0; i_MdRW = '0; i_MdData = '0;
    i_IssueValid = 0; i_IssueRW = '0; i_RA = '0; i_RB = '0;
  endtask

  task automatic do_reset();
    set_idle();
    i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", o_Busy, 32'h0);
    chk("rst_reg_write", 32'(o_RegWrite), 32'h0);
    chk("rst_md_ready", 32'(o_MdReady), 32'h1);
    chk("rst_wb_hold", 32'(o_WbHold), 32'h0);
    @(posedge i_clk);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("post_rst_idle", 32'(o_RegWrite), 32'h0);
  endtask

  initial begin
    set_idle();
    #2;
    do_reset();

    // Lone writeback
    i_WbValid = 1; i_WbRW = 5'd3; i_WbData = 32'hDEADBEEF;
    step();
    chk("wb_we", 32'(o_RegWrite), 32'h1);
    chk("wb_rw", 32'(o_RW), 32'd3);
    chk("wb_data", o_BusW, 32'hDEADBEEF);
    chk("wb_busy", o_Busy, 32'h0);

    // Collision: Wb wins, Md parks and drains next cycle
    set_idle();
    i_WbValid = 1; i_WbRW = 5'd4; i_WbData = 32'h4444_0004;
    i_MdValid = 1; i_MdRW = 5'd7; i_MdData = 32'h7777_0007;
    step();
    chk("col_rw_wb", 32'(o_RW), 32'd4);
    chk("col_ready_low", 32'(o_MdReady), 32'h0);
    set_idle();
    step();
    chk("col_rw_md", 32'(o_RW), 32'd7);
    chk("col_data_md", o_BusW, 32'h7777_0007);
    chk("col_ready_high", 32'(o_MdReady), 32'h1);

    // RAW / WAW / x0 scoreboard
    set_idle();
    i_IssueValid = 1; i_IssueRW = 5'd9;
    step();
    chk("raw_busy_set", o_Busy, 32'h200);
    set_idle(); i_RA = 5'd9;
    #1 chk("raw_stall", 32'(o_Stall), 32'h1);
    step();
    set_idle(); i_IssueValid = 1; i_IssueRW = 5'd9;
    #1 chk("waw_stall", 32'(o_Stall), 32'h1);
    step();
    chk("waw_busy", o_Busy, 32'h200);
    set_idle(); i_IssueValid = 1; i_IssueRW = 5'd0;
    #1 chk("x0_stall", 32'(o_Stall), 32'h0);
    step();
    chk("x0_busy", o_Busy, 32'h200);
    set_idle(); i_RA = 5'd9; i_MdValid = 1; i_MdRW = 5'd9; i_MdData = 32'h0000_0999;
    step();
    chk("raw_wr_rw", 32'(o_RW), 32'd9);
    set_idle(); i_RA = 5'd9;
    #1 chk("raw_stall_wr_cycle", 32'(o_Stall), 32'h1);
    step();
    set_idle(); i_RA = 5'd9;
    #1 chk("raw_stall_clear", 32'(o_Stall), 32'h0);
    chk("raw_busy_clear", o_Busy, 32'h0);
    step();

    // Starvation: hold after LIMIT full cycles, drop after drain
    set_idle();
    i_WbValid = 1; i_WbRW = 5'd13; i_WbData = 32'h1313_1313;
    i_MdValid = 1; i_MdRW = 5'd12; i_MdData = 32'h1212_1212;
    step();
    i_MdValid = 0;
    for (int k = 0; k < 4; k++) begin
      i_WbRW = 5'(14 + k); i_WbData = 32'(k);
      step();
      chk("starve_hold", 32'(o_WbHold), 32'(k == 3));
    end
    i_WbValid = 0;
    step();
    chk("starve_drain_rw", 32'(o_RW), 32'd12);
    chk("starve_hold_drop", 32'(o_WbHold), 32'h0);

    // Reset with the buffer full and a register busy
    set_idle(); i_IssueValid = 1; i_IssueRW = 5'd5;
    step();
    set_idle();
    i_WbValid = 1; i_WbRW = 5'd20; i_MdValid = 1; i_MdRW = 5'd21; i_MdData = 32'h21;
    step();
    chk("pre_rst_full", 32'(o_MdReady), 32'h0);
    chk("pre_rst_busy", o_Busy, 32'h20);
    do_reset();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int busy_list[$];
      set_idle();
      for (int r = 1; r < 32; r++) if (m_busy[r]) busy_list.push_back(r);
      i_WbValid = ($urandom_range(0, 1) == 1) && !m_hold;
      i_WbRW    = 5'($urandom_range(0, 15));
      i_WbData  = $urandom;
      i_MdValid = ($urandom_range(0, 2) == 0);
      if (busy_list.size() != 0 && $urandom_range(0, 3) != 0)
        i_MdRW = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      else
        i_MdRW = 5'($urandom_range(0, 31));
      i_MdData     = $urandom;
      i_IssueValid = ($urandom_range(0, 3) == 0);
      i_IssueRW    = 5'($urandom_range(0, 15));
      i_RA         = 5'($urandom_range(0, 15));
      i_RB         = 5'($urandom_range(0, 15));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file (x0 hardwired zero).
- Arbitrates between pipeline writeback and a multi-cycle unit (MDU/load) result channel, with a 1-entry skid buffer for the multi-cycle unit.
- Keeps a busy scoreboard of registers with outstanding long-latency writes and raises decode stall on RAW/WAW hazards.
- Sits between the writeback stage/MDU and the register file write inputs.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles the skid buffer may stay full before o_WbHold asserts (range 1-15).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_WbValid  in  1  pipeline writeback request. No backpressure except via o_WbHold.
- i_WbRW  in  5  pipeline writeback destination.
- i_WbData  in  32  pipeline writeback data.
- i_MdValid  in  1  multi-cycle result valid (valid/ready handshake).
- i_MdRW  in  5  multi-cycle result destination.
- i_MdData  in  32  multi-cycle result data.
- o_MdReady  out  1  result accepted when i_MdValid & o_MdReady.
- i_IssueValid  in  1  long-latency op issuing this cycle.
- i_IssueRW  in  5  destination of the issuing op.
- i_RA  in  5  decode source A.
- i_RB  in  5  decode source B.
- o_Stall  out  1  decode must stall.
- o_WbHold  out  1  pipeline must present no writeback next cycle.
- o_RegWrite  out  1  to register file write enable.
- o_RW  out  5  to register file write address.
- o_BusW  out  32  to register file write data.
- o_Busy  out  32  scoreboard; bit 0 always 0.

Behaviour:
- Reset (async assert, sync release):
  - o_RegWrite, o_RW, o_BusW, o_WbHold, o_Busy = 0.
  - Buffer empty, starvation counter = 0.
  - Reset mid-operation discards the buffered result and all busy bits.
- o_MdReady = ~buf_full (combinational from state only; never from i_MdValid).
- Per-cycle source selection, priority high to low:
  - (1) buffer, if buf_full & (o_WbHold | ~i_WbValid).
  - (2) Wb, if i_WbValid.
  - (3) Md direct, if Md handshake fires & buffer empty.
- Md handshake in the same cycle as a Wb win: the Md result is captured into the buffer instead.
- Write port outputs are registered, latency 1: selection in cycle N drives o_RegWrite/o_RW/o_BusW in cycle N+1, and the regfile writes at the end of N+1.
- Selected destination 0: o_RegWrite=0 (write dropped); o_RW/o_BusW don't-care.
- No selection in a cycle: o_RegWrite=0 in the next cycle.
- Internal flag from_md is registered alongside o_RegWrite. It is 1 when the source was buffer or Md direct.
- Scoreboard:
  - Set busy[i_IssueRW] when i_IssueValid & i_IssueRW!=0 & ~o_Stall.
  - Clear busy[o_RW] at the edge closing a cycle with o_RegWrite & from_md.
  - Set and clear of the same bit at the same edge: set wins.
  - Wb writes never touch the scoreboard.
- o_Stall (combinational from registered busy):
  - (i_RA!=0 & busy[i_RA]) | (i_RB!=0 & busy[i_RB]) | (i_IssueValid & i_IssueRW!=0 & busy[i_IssueRW]).
  - Stall drops the cycle after the regfile write, when the value is readable.
- Starvation:
  - Counter increments each cycle the buffer is full and not drained; resets to 0 on drain.
  - o_WbHold is registered; it asserts when the counter reaches STARVE_LIMIT and deasserts the cycle after the drain.
  - Pipeline contract: i_WbValid=0 while o_WbHold=1. If violated, the buffer still wins and the Wb request is lost; this is flagged by a simulation assertion.
- A Md result whose destination is not busy is written normally. This is not an error.

Decomposition:
- Shared package: REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0, and a source-select enum {SRC_NONE, SRC_BUF, SRC_WB, SRC_MD}.
- Optional sub-module: wb_skid_buf (1-entry valid/ready buffer holding RW+data). Arbitration and scoreboard stay in the top.

Test Plan:
- Reset mid-operation: pulse i_rst_n low with buffer full and busy[5]=1 -> o_Busy=0, o_MdReady=1, o_RegWrite=0 immediately. The first cycle after release is idle.
- Lone Wb: Wb RW=3, data 0xDEADBEEF at cycle N -> o_RegWrite=1, o_RW=3, o_BusW=0xDEADBEEF at N+1. o_Busy unchanged.
- Collision: Wb RW=4 and Md RW=7 both valid in cycle N -> RW=4 written at N+1. Md is buffered, o_MdReady=0 at N+1. Wb idle at N+1 -> RW=7 written at N+2, o_MdReady=1 at N+2.
- Scoreboard RAW: issue RW=9, then i_RA=9 -> o_Stall=1 until Md RW=9 is written. Stall=0 the cycle after o_RegWrite(RW=9).
- Scoreboard WAW and x0: a second issue to RW=9 while busy -> o_Stall=1, bit stays single-set. Issue RW=0 -> no busy bit, no stall.
- Starvation with STARVE_LIMIT=4: buffer full, i_WbValid held 1 -> o_WbHold=1 after 4 full cycles. The bench drops Wb, the buffer drains next cycle, and o_WbHold returns to 0 one cycle later.
